// File: rtl/gpu_pixel_writer_if.sv
// Pixel-in / framebuffer-write-out bundle for gpu_pixel_writer.
// slave is the writer's side, master is the fill engine plus memory side.
interface gpu_pixel_writer_if #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int ADDR_BITS    = 19
);
    logic                      pix_valid_i;
    logic                      pix_ready_o;
    logic [WIDTH_BITS-1:0]     x_i;
    logic [HEIGHT_BITS-1:0]    y_i;
    logic [CHANNEL_BITS-1:0]   r_i;
    logic [CHANNEL_BITS-1:0]   g_i;
    logic [CHANNEL_BITS-1:0]   b_i;
    logic                      mem_we_o;
    logic [ADDR_BITS-1:0]      mem_addr_o;
    logic [3*CHANNEL_BITS-1:0] mem_wdata_o;
    logic                      mem_ack_i;
    logic                      idle_o;

    modport slave (
        input  pix_valid_i, x_i, y_i, r_i, g_i, b_i, mem_ack_i,
        output pix_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, idle_o
    );

    modport master (
        output pix_valid_i, x_i, y_i, r_i, g_i, b_i, mem_ack_i,
        input  pix_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, idle_o
    );
endinterface

// File: rtl/gpu_pixel_writer.sv
// Pixel -> linear address -> FIFO -> req/ack framebuffer write; 2-edge empty-to-request latency,
// back-to-back writes on ack, pix_ready_o = FIFO not full. GPU_PIXEL_WRITER_CLIP_EN drops off-screen pixels.
module gpu_pixel_writer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 9,
    parameter int CHANNEL_BITS  = 8,
    parameter int ADDR_BITS     = 19,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic clk,
    input  logic n_rst,
    gpu_pixel_writer_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int DAT_W = 3 * CHANNEL_BITS;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SCREEN_WIDTH < 1 || SCREEN_HEIGHT < 1) begin : g_bad_cfg
        $error("gpu_pixel_writer: bad FIFO_DEPTH or screen size");
    end

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DAT_W-1:0]     rgb;
    } entry_t;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    state_t             state_q;
    logic               mem_we_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic [DAT_W-1:0]   mem_wdata_q;

    logic   pix_ready;
    logic   on_screen;
    logic   push;
    logic   pop;
    logic   fifo_nonempty;
    entry_t new_entry;

    assign pix_ready     = (count_q != CNT_W'(FIFO_DEPTH));
    assign fifo_nonempty = (count_q != '0);

`ifdef GPU_PIXEL_WRITER_CLIP_EN
    assign on_screen = (32'(bus.x_i) < 32'(SCREEN_WIDTH)) &&
                       (32'(bus.y_i) < 32'(SCREEN_HEIGHT));
`else
    assign on_screen = 1'b1;
`endif

    // Multiply in ADDR_BITS width so the result wraps modulo 2^ADDR_BITS.
    assign new_entry.addr = ADDR_BITS'(bus.y_i) * ADDR_BITS'(SCREEN_WIDTH) + ADDR_BITS'(bus.x_i);
    assign new_entry.rgb  = {bus.r_i, bus.g_i, bus.b_i};

    assign push = bus.pix_valid_i && pix_ready && on_screen;
    assign pop  = fifo_nonempty && ((state_q == S_IDLE) || bus.mem_ack_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= new_entry;
        end
    end

    // Outputs are loaded directly from the FIFO head on every pop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fifo_nonempty) begin
                        mem_addr_q  <= fifo_mem[rd_ptr_q].addr;
                        mem_wdata_q <= fifo_mem[rd_ptr_q].rgb;
                        mem_we_q    <= 1'b1;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ack_i) begin
                        if (fifo_nonempty) begin
                            mem_addr_q  <= fifo_mem[rd_ptr_q].addr;
                            mem_wdata_q <= fifo_mem[rd_ptr_q].rgb;
                        end else begin
                            mem_we_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pix_ready_o = pix_ready;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.idle_o      = (state_q == S_IDLE) && !fifo_nonempty;
endmodule
